// File: rtl/storage_request_sequencer_if.sv
// storage_request_sequencer_if
//   Bundles the two buses around the sequencer:
//   - core side   : mem_req/gnt request channel plus rvalid/err/rdata responses
//   - controller  : single-access pulse interface to storage_controller
//   The slave modport is the sequencer's view. The master modport is the view
//   of whatever drives the core requests and models the controller.
interface storage_request_sequencer_if #(
  parameter int MEM_W = 32
);
  logic               mem_req_i;
  logic               mem_gnt_o;
  logic               mem_we_i;
  logic [MEM_W/8-1:0] mem_be_i;
  logic [31:0]        mem_addr_i;
  logic [MEM_W-1:0]   mem_wdata_i;
  logic               mem_rvalid_o;
  logic               mem_err_o;
  logic [MEM_W-1:0]   mem_rdata_o;

  logic               sc_memory_access_o;
  logic               sc_memory_is_writing_o;
  logic [31:0]        sc_addr_o;
  logic [31:0]        sc_d_in_o;
  logic [MEM_W/8-1:0] sc_mem_be_o;
  logic [31:0]        sc_d_out_i;
  logic               sc_out_valid_i;

  modport slave (
    input  mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    output mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o,
    output sc_memory_access_o, sc_memory_is_writing_o, sc_addr_o, sc_d_in_o, sc_mem_be_o,
    input  sc_d_out_i, sc_out_valid_i
  );

  modport master (
    output mem_req_i, mem_we_i, mem_be_i, mem_addr_i, mem_wdata_i,
    input  mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o,
    input  sc_memory_access_o, sc_memory_is_writing_o, sc_addr_o, sc_d_in_o, sc_mem_be_o,
    output sc_d_out_i, sc_out_valid_i
  );
endinterface

// File: rtl/storage_request_sequencer.sv
// storage_request_sequencer
//   Queues core memory requests in a small FIFO and issues them one at a time
//   to storage_controller as a single-cycle access pulse. Operands are held
//   stable until the access completes. Responses are returned in order,
//   including write completions, illegal-access errors and read timeouts.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active high
//   bus  - storage_request_sequencer_if.slave carrying the core request and
//          response channel (mem_*) and the controller interface (sc_*)
module storage_request_sequencer #(
  parameter int          MEM_W      = 32,
  parameter int          REQ_DEPTH  = 4,
  parameter logic [31:0] SRAM_LIMIT = 32'h0000_2000,
  parameter int          WR_LAT     = 1,
  parameter int          TIMEOUT    = 1024
)(
  input  logic clk,
  input  logic rst,
  storage_request_sequencer_if.slave bus
);
  localparam int BEW = MEM_W / 8;
  localparam int PW  = $clog2(REQ_DEPTH);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic             we;
    logic [BEW-1:0]   be;
    logic [31:0]      addr;
    logic [MEM_W-1:0] wdata;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

  req_t             r_fifo [REQ_DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  state_t           r_state;
  req_t             r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_access, r_rvalid, r_err, r_timed_out;
  logic [MEM_W-1:0] r_rdata;

  logic w_full, w_push, w_pop;
  req_t w_head;

  // gnt looks only at the registered count, so a pop in the same cycle does
  // not reopen a full FIFO.
  assign w_full        = (r_count == (PW+1)'(REQ_DEPTH));
  assign bus.mem_gnt_o = !rst && !w_full;
  assign w_push        = bus.mem_req_i && bus.mem_gnt_o;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
  assign w_head        = r_fifo[r_rptr];

  // Circular buffer. Because the depth is a power of two, the pointers wrap
  // on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= '{we: bus.mem_we_i, be: bus.mem_be_i,
                            addr: bus.mem_addr_i, wdata: bus.mem_wdata_i};
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sequencer FSM. The pulse and response outputs are registered and default
  // to 0 each cycle, so rdata and err are zero outside the rvalid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_access    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_access <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_hold <= w_head;
          if (w_head.be == '0) begin
            // An empty byte mask completes immediately and never reaches the controller.
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
          end else if (w_head.we && (w_head.addr >= SRAM_LIMIT)) begin
            // External space is read-only.
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_state  <= S_ISSUE;
            r_access <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // The controller never acknowledges a write, so a write completes
          // after a fixed latency. For a read, valid data takes priority over
          // a timeout that occurs in the same cycle.
          if (!r_hold.we && bus.sc_out_valid_i) begin
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= bus.sc_d_out_i;
          end else if (r_hold.we && (r_cnt == CW'(WR_LAT - 1))) begin
            r_state  <= S_RESP;
            r_rvalid <= 1'b1;
          end else if (!r_hold.we && (r_cnt == CW'(TIMEOUT - 1))) begin
            r_state     <= S_RESP;
            r_rvalid    <= 1'b1;
            r_err       <= 1'b1;
            r_timed_out <= 1'b1;
          end
        end
        S_RESP: begin
          // After a timeout the controller still owes a read response. DRAIN
          // absorbs it, unless it has already arrived in this cycle.
          r_timed_out <= 1'b0;
          r_state     <= (r_timed_out && !bus.sc_out_valid_i) ? S_DRAIN : S_IDLE;
        end
        S_DRAIN: if (bus.sc_out_valid_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sc_memory_access_o     = r_access;
  assign bus.sc_memory_is_writing_o = r_hold.we;
  assign bus.sc_addr_o              = r_hold.addr;
  assign bus.sc_d_in_o              = r_hold.wdata;
  assign bus.sc_mem_be_o            = r_hold.be;
  assign bus.mem_rvalid_o           = r_rvalid;
  assign bus.mem_err_o              = r_err;
  assign bus.mem_rdata_o            = r_rdata;
endmodule

// File: tb/tb_storage_request_sequencer.sv
module tb_storage_request_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  storage_request_sequencer_if #(.MEM_W(32)) bus();

  storage_request_sequencer #(
    .MEM_W(32), .REQ_DEPTH(4), .SRAM_LIMIT(32'h0000_2000), .WR_LAT(1), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Controller model: an SRAM read is answered on the cycle after the pulse,
  // or once stall is released. External reads are never answered unless late
  // is raised, which injects a stray read-data beat.
  bit          stall = 1'b0;
  bit          late  = 1'b0;
  bit          pend  = 1'b0;
  logic [31:0] pend_d;

  function automatic logic [31:0] model_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    bus.sc_out_valid_i = 1'b0;
    bus.sc_d_out_i     = '0;
    if (late) begin
      bus.sc_out_valid_i = 1'b1;
      bus.sc_d_out_i     = 32'hBAD0BAD0;
    end else if (pend && !stall) begin
      bus.sc_out_valid_i = 1'b1;
      bus.sc_d_out_i     = pend_d;
      pend               = 1'b0;
    end
    if (bus.sc_memory_access_o && !bus.sc_memory_is_writing_o && bus.sc_addr_o < 32'h2000) begin
      pend   = 1'b1;
      pend_d = model_data(bus.sc_addr_o);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_pulse;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // One isolated transaction. The request is presented in cycle 0. The task
  // then checks the pulse timing, the stability of the held operands and the
  // cycle in which the response arrives.
  task automatic run_vec(input int id, input vec_t v);
    int          pulse_n = 0, pulse_c = -1, rv_n = 0, rv_c = -1;
    logic        rv_err = 1'b0;
    logic [31:0] rv_data = '0;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = v.we;
    bus.mem_be_i    = v.be;
    bus.mem_addr_i  = v.addr;
    bus.mem_wdata_i = v.wdata;
    chk($sformatf("v%0d_gnt", id), bus.mem_gnt_o, 1);
    step();
    bus.mem_req_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.sc_memory_access_o) begin pulse_n++; pulse_c = c; end
      if (v.exp_pulse && (c == 2 || c == 3)) begin
        chk($sformatf("v%0d_c%0d_addr", id, c), bus.sc_addr_o, v.addr);
        chk($sformatf("v%0d_c%0d_we", id, c), bus.sc_memory_is_writing_o, v.we);
        chk($sformatf("v%0d_c%0d_be", id, c), bus.sc_mem_be_o, v.be);
        chk($sformatf("v%0d_c%0d_wdata", id, c), bus.sc_d_in_o, v.wdata);
      end
      if (bus.mem_rvalid_o) begin
        rv_n++; rv_c = c; rv_err = bus.mem_err_o; rv_data = bus.mem_rdata_o;
      end else begin
        chk($sformatf("v%0d_c%0d_quiet", id, c), bus.mem_rdata_o | {31'b0, bus.mem_err_o}, 0);
      end
      step();
    end
    chk($sformatf("v%0d_pulses", id), pulse_n, v.exp_pulse ? 1 : 0);
    if (v.exp_pulse) chk($sformatf("v%0d_pulse_cyc", id), pulse_c, 2);
    chk($sformatf("v%0d_rvalids", id), rv_n, 1);
    chk($sformatf("v%0d_rvalid_cyc", id), rv_c, v.exp_pulse ? 4 : 2);
    chk($sformatf("v%0d_err", id), rv_err, v.exp_err);
    chk($sformatf("v%0d_rdata", id), rv_data, v.exp_rdata);
  endtask

  task automatic drive_read(input logic [31:0] a);
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b0;
    bus.mem_be_i    = 4'hF;
    bus.mem_addr_i  = a;
    bus.mem_wdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx, nresp, acc_win, pulses_n, rv_n;
    int          pulse_cyc[4];
    int          rv_cyc[4];
    logic        rv_err[4];
    logic [31:0] rv_dat[4];
    logic        take;

    //            we    be     addr          wdata        pulse err rdata
    vecs[0] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,        1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'h3, 32'h0000_0040, 32'h12345678, 1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'hF, 32'h0000_2000, 32'h55AA55AA, 0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 4'h0, 32'h0000_0080, 32'h0,        0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 4'hF, 32'h0000_1FFC, 32'h0,        1, 1'b0, 32'h1FFCE003};
    vecs[5] = '{1'b1, 4'h8, 32'h0000_1FFC, 32'hCAFEF00D, 1, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 4'h0, 32'h0000_2000, 32'h11111111, 0, 1'b0, 32'h0};

    rst = 1'b1;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_be_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    step(); step();
    chk("rst_gnt", bus.mem_gnt_o, 0);
    chk("rst_access", bus.sc_memory_access_o, 0);
    chk("rst_rvalid", bus.mem_rvalid_o, 0);
    chk("rst_addr", bus.sc_addr_o, 0);
    rst = 1'b0;
    step();
    chk("post_rst_gnt", bus.mem_gnt_o, 1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: one read is stalled in WAIT, then five more are offered.
    // Exactly four are accepted before gnt drops.
    stall = 1'b1; idx = 0; nresp = 0; acc_win = 0;
    for (int c = 0; c < 150 && nresp < 6; c++) begin
      take = 1'b0;
      if (bus.mem_rvalid_o) begin
        chk($sformatf("bp_rsp%0d_data", nresp), bus.mem_rdata_o, model_data(32'h200 + 32'(4 * nresp)));
        chk($sformatf("bp_rsp%0d_err", nresp), bus.mem_err_o, 0);
        nresp++;
      end
      if (c == 12) stall = 1'b0;
      if (idx < 6 && (idx == 0 || c >= 4)) begin
        drive_read(32'h200 + 32'(4 * idx));
        take = bus.mem_gnt_o;
      end else bus.mem_req_i = 1'b0;
      if (c >= 4 && c < 12 && take) acc_win++;
      if (c == 11) chk("bp_gnt_low", bus.mem_gnt_o, 0);
      step();
      if (take) idx++;
    end
    bus.mem_req_i = 1'b0;
    chk("bp_accepts_while_stalled", acc_win, 4);
    chk("bp_responses", nresp, 6);
    step(); step();

    // External read timeout, followed by a request queued during DRAIN and
    // a late controller beat that must not be forwarded.
    pulses_n = 0; rv_n = 0;
    drive_read(32'h3000);
    step();
    bus.mem_req_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.sc_memory_access_o && pulses_n < 4) begin pulse_cyc[pulses_n] = c; pulses_n++; end
      if (bus.mem_rvalid_o && rv_n < 4) begin
        rv_cyc[rv_n] = c; rv_err[rv_n] = bus.mem_err_o; rv_dat[rv_n] = bus.mem_rdata_o; rv_n++;
      end
      if (c == 20) begin chk("to_gnt_in_drain", bus.mem_gnt_o, 1); drive_read(32'h104); end
      else bus.mem_req_i = 1'b0;
      late = (c == 30);
      step();
    end
    late = 1'b0;
    chk("to_pulses", pulses_n, 2);
    chk("to_pulse0_cyc", pulse_cyc[0], 2);
    chk("to_pulse1_cyc", pulse_cyc[1], 32);
    chk("to_rvalids", rv_n, 2);
    chk("to_rv0_cyc", rv_cyc[0], 19);
    chk("to_rv0_err", rv_err[0], 1);
    chk("to_rv0_data", rv_dat[0], 0);
    chk("to_rv1_cyc", rv_cyc[1], 34);
    chk("to_rv1_err", rv_err[1], 0);
    chk("to_rv1_data", rv_dat[1], model_data(32'h104));

    // Reset while one read sits in WAIT and three more are queued.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_read(32'h300 + 32'(4 * i));
      chk($sformatf("mr_gnt%0d", i), bus.mem_gnt_o, 1);
      step();
    end
    bus.mem_req_i = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("mr_gnt", bus.mem_gnt_o, 0);
    chk("mr_access", bus.sc_memory_access_o, 0);
    chk("mr_rvalid", bus.mem_rvalid_o, 0);
    chk("mr_err", bus.mem_err_o, 0);
    chk("mr_rdata", bus.mem_rdata_o, 0);
    chk("mr_we", bus.sc_memory_is_writing_o, 0);
    chk("mr_addr", bus.sc_addr_o, 0);
    chk("mr_din", bus.sc_d_in_o, 0);
    chk("mr_be", bus.sc_mem_be_o, 0);
    step();
    rst = 1'b0;
    stall = 1'b0;
    pulses_n = 0; rv_n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.sc_memory_access_o) pulses_n++;
      if (bus.mem_rvalid_o) rv_n++;
      step();
    end
    chk("mr_no_pulse_after", pulses_n, 0);
    chk("mr_no_rvalid_after", rv_n, 0);
    run_vec(100, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/storage_request_sequencer.md
Name: storage_request_sequencer

Overview:
- Sits directly upstream of storage_controller, between the vector core's memory port (req/gnt/rvalid, MEM_W bus) and the controller's single-access interface.
- Buffers core requests in a small FIFO and issues them one at a time to storage_controller as a one-cycle access pulse, holding the operands stable until the access completes.
- Generates in-order responses, including completion for writes (which storage_controller does not acknowledge) and error responses for illegal accesses and timeouts.

Parameters:
- MEM_W, 32, memory bus width in bits; only 32 is supported.
- REQ_DEPTH, 4, request FIFO depth in entries; must be a power of 2 and at least 2.
- SRAM_LIMIT, 32'h0000_2000, first address not backed by SRAM. Addresses at or above it are external and read-only.
- WR_LAT, 1, number of WAIT cycles after which a write is considered complete.
- TIMEOUT, 1024, maximum WAIT cycles before a read is failed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- mem_req_i  in  1  core request valid.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_we_i  in  1  1 = write.
- mem_be_i  in  MEM_W/8  byte enables.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  MEM_W  write data.
- mem_rvalid_o  out  1  response valid, one-cycle pulse.
- mem_err_o  out  1  response error, valid with mem_rvalid_o.
- mem_rdata_o  out  MEM_W  read data, valid with mem_rvalid_o.
- sc_memory_access_o  out  1  access pulse to storage_controller.
- sc_memory_is_writing_o  out  1  write flag.
- sc_addr_o  out  32  address.
- sc_d_in_o  out  32  write data.
- sc_mem_be_o  out  MEM_W/8  byte enables.
- sc_d_out_i  in  32  read data.
- sc_out_valid_i  in  1  read data valid.

Behaviour:
- Reset: FIFO emptied and queued requests dropped; state goes to IDLE. All outputs are 0 at reset except mem_gnt_o, which is 1 from the first cycle after reset. Reset asserted mid-access aborts the access with no response.
- Accept: mem_gnt_o = !fifo_full. A request is pushed when mem_req_i && mem_gnt_o. When the FIFO is full, a pop in the same cycle does not raise gnt; gnt depends on the registered count only.
- FIFO: circular buffer with REQ_DEPTH entries of {we, be, addr, wdata}. Pointers wrap modulo REQ_DEPTH. Simultaneous push and pop leaves the count unchanged.
- IDLE:
  - If the FIFO is empty, stay in IDLE.
  - Otherwise pop the head into the hold registers and classify it:
  - be == 0: go to RESP with err=0 and rdata=0; no access is issued.
  - we=1 and addr >= SRAM_LIMIT: go to RESP with err=1; no access is issued.
  - Anything else: go to ISSUE.
- ISSUE:
  - sc_memory_access_o = 1 for exactly this one cycle.
  - Clear the wait counter, then go to WAIT.
- WAIT:
  - sc_memory_access_o = 0. sc_addr_o, sc_d_in_o, sc_mem_be_o and sc_memory_is_writing_o stay driven from the hold registers, from ISSUE through the end of WAIT.
  - The wait counter increments every WAIT cycle.
  - Read completion: sc_out_valid_i = 1. Latch sc_d_out_i and go to RESP with err=0.
  - Write completion: the counter reaches WR_LAT-1. Go to RESP with err=0 and rdata=0.
  - Read timeout: the counter reaches TIMEOUT-1 without sc_out_valid_i. Go to RESP with err=1 and rdata=0, then enter DRAIN instead of IDLE.
  - If sc_out_valid_i and the timeout occur in the same cycle, valid data wins.
- RESP: mem_rvalid_o = 1 for one cycle with mem_err_o and mem_rdata_o from registers. Then go to IDLE, or to DRAIN after a timeout.
- DRAIN: no issue. Wait for sc_out_valid_i and discard the data, then go to IDLE. The FIFO keeps accepting requests during DRAIN.
- Ordering: responses are returned in request order; at most one access is outstanding at storage_controller.
- Latency with an empty FIFO and a request accepted at cycle 0:
  - Pop and hold-register load at cycle 1.
  - sc_memory_access_o at cycle 2.
  - With the controller returning sc_out_valid_i at cycle 3 (SRAM read) or WR_LAT=1, mem_rvalid_o at cycle 4.
- Back-to-back throughput: one access per 4 cycles for SRAM.
- mem_rdata_o and mem_err_o are 0 whenever mem_rvalid_o = 0.

Test Plan:
- Single SRAM read: request addr 0x100 with the controller model returning 0xDEADBEEF one cycle after the pulse. Expect gnt at cycle 0, access pulse at cycle 2 only, rvalid at cycle 4 with rdata 0xDEADBEEF and err=0.
- SRAM write: addr 0x40, be 4'b0011, wdata 0x12345678. Expect sc_* outputs stable from cycle 2 through WAIT, then rvalid at cycle 4 with err=0 and rdata 0.
- Illegal accesses: a write to 0x2000 and a request with be=0. Expect no access pulse, and rvalid with err=1 and err=0 respectively.
- Backpressure: hold mem_req_i high for 6 requests with the controller stalled. Expect gnt to drop after 4 accepts, and responses to come back in order with the correct data once the controller resumes.
- External read timeout: read 0x3000 with no sc_out_valid_i, TIMEOUT=16. Expect rvalid with err=1 16 WAIT cycles after entering WAIT, no new pulse until a late sc_out_valid_i, and that late data not forwarded.
- Reset with 3 queued requests and one in WAIT: expect all outputs 0, no rvalid afterwards, and a fresh request completing normally.
